// File: rtl/buf_arbiter.sv
// ---------------------------------------------------------------------------
// buf_arbiter
//
// Purpose:
//   Shares one single-port buffer between two requesters: port A (Wishbone
//   side) and port B (SPI side). Each access runs IDLE -> ACCESS -> RESP, so
//   a request sampled in cycle 0 is acknowledged in cycle 2. Addresses at or
//   above DEPTH are not forwarded to the buffer; they complete with err=1
//   and rdata=0.
//
// Arbitration:
//   Default build: simultaneous requests are resolved round-robin (the port
//   not granted last wins; after reset B counts as last-granted, so A wins
//   first). Define BUF_ARB_FIXED_PRIO_EN to give port A fixed priority.
//
// Ports:
//   CLK_I, RST_I               clock, asynchronous active-high reset
//   a_req/b_req                request, held high until ack
//   a_we/b_we                  1 = write, 0 = read
//   a_addr/b_addr              word address
//   a_wdata/b_wdata            write data
//   a_ack/b_ack                one-cycle completion pulse
//   a_err/b_err                address error, valid with ack
//   a_rdata/b_rdata            read data, valid with ack, held until next ack
//   mem_en/mem_we/mem_addr/mem_wdata   buffer command (active in ACCESS only)
//   mem_rdata                  buffer read data, valid one cycle after mem_en
//   busy                       FSM not in IDLE
//
// Handshake: a requester raises req with we/addr/wdata stable and holds it
// until it sees ack; it drops req on the clock edge that ends the ack cycle.
// A req still high in the following IDLE cycle is treated as a new request.
// ---------------------------------------------------------------------------
module buf_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 42
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < DEPTH_U);
    endfunction

    state_t              state_q,   state_d;
    logic                win_b_q,   win_b_d;    // transaction owner: 1 = B
    logic                last_b_q,  last_b_d;   // last granted port: 1 = B
    logic                we_q,      we_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic                legal_q,   legal_d;
    logic                mem_en_q,  mem_en_d;
    logic                mem_we_q,  mem_we_d;
    logic                a_ack_q,   a_ack_d;
    logic                b_ack_q,   b_ack_d;
    logic                a_err_q,   a_err_d;
    logic                b_err_q,   b_err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                rd_live_q, rd_live_d;  // RESP of a legal read

    // Winner selection; only meaningful when at least one req is high.
    logic                grant_b;
`ifdef BUF_ARB_FIXED_PRIO_EN
    assign grant_b = ~a_req;
`else
    assign grant_b = b_req & (~a_req | ~last_b_q);
`endif

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_legal;

    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;
    assign sel_legal = addr_legal(sel_addr);

    always_comb begin
        state_d   = state_q;
        win_b_d   = win_b_q;
        last_b_d  = last_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        legal_d   = legal_q;
        a_err_d   = a_err_q;
        b_err_d   = b_err_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        // Single-cycle strobes default low.
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        rd_live_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d  = ST_ACCESS;
                    win_b_d  = grant_b;
                    last_b_d = grant_b;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    legal_d  = sel_legal;
                    // Buffer command is registered so it is high exactly
                    // during ACCESS.
                    mem_en_d = sel_legal;
                    mem_we_d = sel_legal & sel_we;
                end
            end
            ST_ACCESS: begin
                state_d   = ST_RESP;
                rd_live_d = legal_q & ~we_q;
                if (win_b_q) begin
                    b_ack_d = 1'b1;
                    b_err_d = ~legal_q;
                    if (!legal_q) b_rdata_d = '0;
                end else begin
                    a_ack_d = 1'b1;
                    a_err_d = ~legal_q;
                    if (!legal_q) a_rdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // Hold the read word for the requester after the ack cycle.
                if (rd_live_q) begin
                    if (win_b_q) b_rdata_d = mem_rdata;
                    else         a_rdata_d = mem_rdata;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            win_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            legal_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            rd_live_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_b_q   <= win_b_d;
            last_b_q  <= last_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            legal_q   <= legal_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            rd_live_q <= rd_live_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign busy      = (state_q != ST_IDLE);

    // The buffer word arrives in the ack cycle, so it is passed straight
    // through then and taken from the holding register afterwards.
    assign a_rdata = (rd_live_q && !win_b_q) ? mem_rdata : a_rdata_q;
    assign b_rdata = (rd_live_q &&  win_b_q) ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_buf_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buf_arbiter
//
// Directed bench for buf_arbiter with a behavioural single-port buffer.
// Each issued transaction pushes its expected completion {port, check-rdata,
// err, rdata} into exp_q; a monitor on the falling edge pops and compares on
// every ack. Driver tasks also check cycle-exact timing of the buffer
// command, ack latency and reset behaviour.
// ---------------------------------------------------------------------------
module tb_buf_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int EXP_W = 35;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, a_err, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    buf_arbiter dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_err    (a_err),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_err    (b_err),
        .b_rdata  (b_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- buffer model ----------------
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_b, input logic chk_rd, input logic err,
                            input logic [DW-1:0] rd);
        exp_q.push_back({is_b, chk_rd, err, rd});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (a_ack || b_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got a_ack=%b b_ack=%b, required none", a_ack, b_ack);
            end else begin
                mon_e = exp_q.pop_front();
                chk1("ack_port_b", b_ack, mon_e[34]);
                chk1("ack_port_a", a_ack, ~mon_e[34]);
                chk1("ack_err", mon_e[34] ? b_err : a_err, mon_e[32]);
                if (mon_e[33])
                    chk("ack_rdata", mon_e[34] ? b_rdata : a_rdata, mon_e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One isolated request; cycle 0 is the cycle in which req is first sampled.
    task automatic single(input logic is_b, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic exp_err,
                          input logic [DW-1:0] exp_rd);
        logic legal;
        legal = ~exp_err;
        push_exp(is_b, ~we | exp_err, exp_err, exp_rd);
        @(posedge clk); #1;
        if (is_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        @(posedge clk); #1;                       // cycle 1: ACCESS
        chk1("busy_c1", busy, 1'b1);
        chk1("mem_en_c1", mem_en, legal);
        chk1("mem_we_c1", mem_we, we & legal);
        if (legal) begin
            chk("mem_addr_c1", 32'(mem_addr), 32'(addr));
            if (we) chk("mem_wdata_c1", mem_wdata, wd);
        end
        @(posedge clk); #1;                       // cycle 2: RESP
        chk1("ack_c2", is_b ? b_ack : a_ack, 1'b1);
        chk1("mem_en_c2", mem_en, 1'b0);
        @(posedge clk); #1;                       // edge ending the ack cycle
        if (is_b) b_req = 1'b0;
        else      a_req = 1'b0;
        chk1("ack_one_cycle", a_ack | b_ack, 1'b0);
        chk1("busy_idle", busy, 1'b0);
    endtask

    // Both ports hold a read request of address 5 continuously.
    task automatic both_hold();
        int acks;
        int cyc;
`ifdef BUF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        push_exp(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
`else
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
            push_exp(1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        end
`endif
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd5; b_wdata = '0;
        acks = 0;
        cyc  = 0;
        while (acks < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack || b_ack) acks++;
        end
        chk("contend_acks", acks, 4);
        @(posedge clk); #1;                       // edge ending the 4th ack cycle
`ifdef BUF_ARB_FIXED_PRIO_EN
        a_req = 1'b0;
        cyc = 0;
        while (!b_ack && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk1("b_after_a_idle", b_ack, 1'b1);
        @(posedge clk); #1;
        b_req = 1'b0;
`else
        a_req = 1'b0;
        b_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk1("contend_idle", busy, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_a_ack", a_ack, 1'b0);
        chk1("rst_b_ack", b_ack, 1'b0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        rst = 1'b0;

        // A write, B read back, A's read data must not move.
        single(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 32'h0);
        single(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 32'hDEADBEEF);
        chk("a_rdata_kept_1", a_rdata, 32'h0);

        // Highest legal address, then B read while A holds data.
        single(1'b1, 1'b1, 6'd41, 32'h12345678, 1'b0, 32'h0);
        single(1'b0, 1'b0, 6'd41, 32'h0, 1'b0, 32'h12345678);
        single(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 32'hDEADBEEF);
        chk("a_rdata_kept_2", a_rdata, 32'h12345678);
        chk("b_rdata_held", b_rdata, 32'hDEADBEEF);

        // Simultaneous requests.
        both_hold();

        // First illegal address, on both ports.
        single(1'b0, 1'b0, 6'd42, 32'h0, 1'b1, 32'h0);
        chk("a_rdata_err_held", a_rdata, 32'h0);
        single(1'b1, 1'b0, 6'd63, 32'h0, 1'b1, 32'h0);
        chk1("a_err_held", a_err, 1'b1);
        single(1'b1, 1'b0, 6'd5, 32'h0, 1'b0, 32'hDEADBEEF);
        chk1("b_err_cleared", b_err, 1'b0);

        // Reset in the middle of an access: no ack, clean restart.
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        chk1("mid_busy", busy, 1'b1);
        chk1("mid_mem_en", mem_en, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_busy", busy, 1'b0);
        chk1("async_mem_en", mem_en, 1'b0);
        chk1("async_a_err", a_err, 1'b0);
        a_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("abort_no_ack", a_ack, 1'b0);
        single(1'b0, 1'b0, 6'd5, 32'h0, 1'b0, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
